// File: rtl/param_processor_pkg.sv
// param_processor_pkg: opcodes, FSM state encoding and decode helpers shared by the processor and its ALU.
package param_processor_pkg;

    localparam logic [3:0] OP_MV  = 4'd0;
    localparam logic [3:0] OP_MVI = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_NEG = 4'd8;
    localparam logic [3:0] OP_SHL = 4'd9;
    localparam logic [3:0] OP_SHR = 4'd10;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] T1   = 2'd1;
    localparam logic [1:0] T2   = 2'd2;
    localparam logic [1:0] T3   = 2'd3;

    function automatic logic is_binary(input logic [3:0] op);
        return op >= OP_ADD && op <= OP_XOR;
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return op <= OP_SHR;
    endfunction

endpackage

// File: rtl/param_processor_alu.sv
// param_processor_alu: combinational ALU; unary ops use a only, Z/C derived from the result.
module param_processor_alu
    import param_processor_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              z,
    output logic              c
);

    always_comb begin
        result = b;
        c      = 1'b0;
        case (op)
            OP_ADD:  {c, result} = {1'b0, a} + {1'b0, b};
            OP_SUB:  begin
                result = a - b;
                c      = a < b;
            end
            OP_OR:   result = a | b;
            OP_AND:  result = a & b;
            OP_XOR:  result = a ^ b;
            OP_NOT:  result = ~a;
            OP_NEG:  result = '0 - a;
            OP_SHL:  {c, result} = {a, 1'b0};
            OP_SHR:  {result, c} = {1'b0, a};
            default: result = b;
        endcase
    end

    assign z = result == '0;

endmodule

// File: rtl/param_processor.sv
// param_processor: multi-cycle register-file processor with run/done/busy handshake,
// Z/C flags, illegal-opcode detection and a read-only register view port.
module param_processor
    import param_processor_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS = 8,
    localparam int REG_IDX_W = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic [DATA_W-1:0]    dataIn,
    output logic                 done,
    output logic                 busy,
    output logic                 illegal,
    output logic [DATA_W-1:0]    bus,
    input  logic [REG_IDX_W-1:0] regSel,
    output logic [DATA_W-1:0]    regOut,
    output logic                 flagZ,
    output logic                 flagC
);

    logic [1:0]           state_q, state_d;
    logic [3:0]           op_q, op_d;
    logic [REG_IDX_W-1:0] x_q, x_d, y_q, y_d;
    logic [DATA_W-1:0]    a_q, a_d, g_q, g_d;
    logic                 zs_q, zs_d, cs_q, cs_d, z_q, z_d, c_q, c_d;
    logic [DATA_W-1:0]    r_q [NREGS];
    logic [DATA_W-1:0]    r_d [NREGS];
    logic [DATA_W-1:0]    alu_res;
    logic                 alu_z, alu_c;
    logic                 legal, bin, mov, unary, wr;

    assign legal = is_legal(op_q);
    assign bin   = is_binary(op_q);
    assign mov   = op_q <= OP_MVI;
    assign unary = legal && !bin && !mov;

    // ALU b always taps R[Y] directly so the unary T2 path (bus = alu) has no loop.
    param_processor_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (r_q[y_q]),
        .result (alu_res),
        .z      (alu_z),
        .c      (alu_c)
    );

    assign bus = state_q == T3 ? g_q :
                 state_q == T2 ? (bin ? r_q[y_q] : alu_res) :
                 state_q == T1 && (op_q == OP_MV || unary) ? r_q[y_q] :
                 state_q == T1 && bin ? r_q[x_q] : dataIn;

    assign done    = (state_q == T1 && (mov || !legal)) || (state_q == T2 && !bin) || state_q == T3;
    assign wr      = (state_q == T1 && mov) || (state_q == T2 && !bin) || state_q == T3;
    assign illegal = state_q == T1 && !legal;
    assign busy    = state_q != IDLE;
    assign regOut  = r_q[regSel];
    assign flagZ   = z_q;
    assign flagC   = c_q;

    always_comb begin
        state_d = state_q == IDLE ? (run ? T1 : IDLE) :
                  state_q == T1   ? (legal && !mov ? T2 : IDLE) :
                  state_q == T2   ? (bin ? T3 : IDLE) : IDLE;
        op_d  = op_q;
        x_d   = x_q;
        y_d   = y_q;
        a_d   = a_q;
        g_d   = g_q;
        zs_d  = zs_q;
        cs_d  = cs_q;
        z_d   = z_q;
        c_d   = c_q;
        r_d   = r_q;
        if (state_q == IDLE && run) begin
            op_d = dataIn[DATA_W-1 -: 4];
            x_d  = dataIn[2*REG_IDX_W-1 -: REG_IDX_W];
            y_d  = dataIn[REG_IDX_W-1:0];
        end
        if (state_q == T1 && legal && !mov)
            a_d = bus;
        if (state_q == T2 && bin) begin
            g_d  = alu_res;
            zs_d = alu_z;
            cs_d = alu_c;
        end
        if (state_q == T2 && !bin) begin
            z_d = alu_z;
            c_d = alu_c;
        end
        if (state_q == T3) begin
            z_d = zs_q;
            c_d = cs_q;
        end
        if (wr)
            r_d[x_q] = bus;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            a_q     <= '0;
            g_q     <= '0;
            zs_q    <= 1'b0;
            cs_q    <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            r_q     <= '{default: '0};
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            x_q     <= x_d;
            y_q     <= y_d;
            a_q     <= a_d;
            g_q     <= g_d;
            zs_q    <= zs_d;
            cs_q    <= cs_d;
            z_q     <= z_d;
            c_q     <= c_d;
            r_q     <= r_d;
        end
    end

endmodule

// File: tb/tb_param_processor.sv
// tb_param_processor: scoreboard bench driving a 16-bit/8-reg and an 8-bit/4-reg processor.
module tb_param_processor;

    typedef struct {
        int          k;
        logic [15:0] r;
        logic        z;
        logic        c;
        logic        ill;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  run_v = 2'b00;
    logic [15:0] din0 = 16'h0000;
    logic [7:0]  din1 = 8'h00;
    logic [2:0]  sel0 = 3'd0;
    logic [1:0]  sel1 = 2'd0;
    logic [1:0]  done_v, busy_v, ill_v, z_v, c_v;
    logic [15:0] bus0, reg0;
    logic [7:0]  bus1, reg1;

    exp_t q[$];
    int   total = 0;
    int   passed = 0;
    int   cnt[2];

    always #5 clk = ~clk;

    param_processor #(.DATA_W(16), .NREGS(8)) u0 (
        .clk(clk), .reset(reset), .run(run_v[0]), .dataIn(din0), .done(done_v[0]),
        .busy(busy_v[0]), .illegal(ill_v[0]), .bus(bus0), .regSel(sel0), .regOut(reg0),
        .flagZ(z_v[0]), .flagC(c_v[0])
    );

    param_processor #(.DATA_W(8), .NREGS(4)) u1 (
        .clk(clk), .reset(reset), .run(run_v[1]), .dataIn(din1), .done(done_v[1]),
        .busy(busy_v[1]), .illegal(ill_v[1]), .bus(bus1), .regSel(sel1), .regOut(reg1),
        .flagZ(z_v[1]), .flagC(c_v[1])
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [15:0] rd(input int k);
        return k == 0 ? reg0 : {8'h00, reg1};
    endfunction

    task automatic setin(input int k, input logic [15:0] d, input logic [3:0] s);
        if (k == 0) begin
            din0 = d;
            sel0 = s[2:0];
        end else begin
            din1 = d[7:0];
            sel1 = s[1:0];
        end
    endtask

    task automatic issue(input int k, input logic [15:0] ins, input logic [15:0] imm,
                         input logic [3:0] sel, input logic [15:0] r, input logic z,
                         input logic c, input logic ill, input int lat, input logic pulse);
        exp_t e;
        int   n;
        @(negedge clk);
        setin(k, ins, sel);
        run_v[k] = 1'b1;
        e.k = k; e.r = r; e.z = z; e.c = c; e.ill = ill; e.lat = lat;
        q.push_back(e);
        @(negedge clk);
        run_v[k] = pulse;
        setin(k, imm, sel);
        n = 0;
        while (busy_v[k] && n < 10) begin
            @(negedge clk);
            n++;
            if (n >= 2) run_v[k] = 1'b0;
        end
        chk("busy_drop", {15'd0, busy_v[k]}, 16'd0);
        if (pulse) begin
            @(negedge clk);
            chk("run_ignored_while_busy", {15'd0, busy_v[k]}, 16'd0);
        end
    endtask

    // Monitor: latency/illegal checked in the done cycle, writeback just after its edge.
    initial begin
        exp_t pe;
        int   pk;
        cnt[0] = 0;
        cnt[1] = 0;
        pk = -1;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                cnt[k] = busy_v[k] ? cnt[k] + 1 : 0;
                if (done_v[k]) begin
                    if (q.size() == 0) begin
                        chk("sb_spurious_done", {15'd0, done_v[k]}, 16'd0);
                    end else begin
                        pe = q.pop_front();
                        pk = k;
                        chk("sb_dut", 16'(k), 16'(pe.k));
                        chk("latency", 16'(cnt[k] + 1), 16'(pe.lat));
                        chk("illegal", {15'd0, ill_v[k]}, {15'd0, pe.ill});
                    end
                end
            end
            if (pk >= 0) begin
                @(posedge clk);
                #1;
                chk("regOut", rd(pk), pe.r);
                chk("flagZ", {15'd0, z_v[pk]}, {15'd0, pe.z});
                chk("flagC", {15'd0, c_v[pk]}, {15'd0, pe.c});
                pk = -1;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [5:0] dv;
        exp_t       e;
        din0 = 16'hA5A5;
        din1 = 8'h5A;
        repeat (2) @(negedge clk);
        chk("rst_busy", {14'd0, busy_v}, 16'd0);
        chk("rst_done", {14'd0, done_v}, 16'd0);
        chk("rst_flags", {12'd0, z_v, c_v}, 16'd0);
        chk("rst_reg0", reg0, 16'h0000);
        chk("idle_bus0", bus0, 16'hA5A5);
        chk("idle_bus1", {8'd0, bus1}, 16'h005A);
        reset = 1'b0;

        issue(0, 16'h1000, 16'h0005, 4'd0, 16'h0005, 1'b0, 1'b0, 1'b0, 2, 1'b0);
        issue(0, 16'h1008, 16'hFFFE, 4'd1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 2, 1'b0);
        issue(0, 16'h2001, 16'h0000, 4'd0, 16'h0003, 1'b0, 1'b1, 1'b0, 4, 1'b0);
        issue(0, 16'h1010, 16'h1234, 4'd2, 16'h1234, 1'b0, 1'b1, 1'b0, 2, 1'b0);
        issue(0, 16'h3012, 16'h0000, 4'd2, 16'h0000, 1'b1, 1'b0, 1'b0, 4, 1'b0);
        issue(0, 16'h1020, 16'h0001, 4'd4, 16'h0001, 1'b1, 1'b0, 1'b0, 2, 1'b0);
        issue(0, 16'hA01C, 16'h0000, 4'd3, 16'h0000, 1'b1, 1'b1, 1'b0, 3, 1'b0);
        issue(0, 16'hF000, 16'h0000, 4'd0, 16'h0003, 1'b1, 1'b1, 1'b1, 2, 1'b0);
        issue(0, 16'h0029, 16'h0000, 4'd5, 16'hFFFE, 1'b1, 1'b1, 1'b0, 2, 1'b0);
        issue(0, 16'h6028, 16'h0000, 4'd5, 16'hFFFD, 1'b0, 1'b0, 1'b0, 4, 1'b0);
        issue(0, 16'h7030, 16'h0000, 4'd6, 16'hFFFC, 1'b0, 1'b0, 1'b0, 3, 1'b0);
        issue(0, 16'h9039, 16'h0000, 4'd7, 16'hFFFC, 1'b0, 1'b1, 1'b0, 3, 1'b0);
        issue(0, 16'h4004, 16'h0000, 4'd0, 16'h0003, 1'b0, 1'b0, 1'b0, 4, 1'b0);
        issue(0, 16'h5001, 16'h1038, 4'd0, 16'h0002, 1'b0, 1'b0, 1'b0, 4, 1'b1);
        issue(0, 16'h3021, 16'h0000, 4'd4, 16'h0003, 1'b0, 1'b1, 1'b0, 4, 1'b0);
        issue(0, 16'h8014, 16'h0000, 4'd2, 16'hFFFD, 1'b0, 1'b0, 1'b0, 3, 1'b0);

        // run held high: NOT R6,R6 twice with one IDLE cycle between
        @(negedge clk);
        setin(0, 16'h7036, 4'd6);
        run_v[0] = 1'b1;
        e.k = 0; e.z = 1'b0; e.c = 1'b0; e.ill = 1'b0; e.lat = 3;
        e.r = 16'h0003;
        q.push_back(e);
        e.r = 16'hFFFC;
        q.push_back(e);
        dv = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            dv[i] = done_v[0];
            if (i == 3) run_v[0] = 1'b0;
        end
        chk("b2b_done_pattern", {10'd0, dv}, 16'h0012);

        // reset during T2 of ADD R0,R1 aborts it
        @(negedge clk);
        setin(0, 16'h2001, 4'd0);
        run_v[0] = 1'b1;
        @(negedge clk);
        run_v[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", {15'd0, busy_v[0]}, 16'd0);
        chk("abort_done", {15'd0, done_v[0]}, 16'd0);
        chk("abort_flags", {14'd0, z_v[0], c_v[0]}, 16'd0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            setin(0, 16'h0000, 4'(i));
            #1;
            chk($sformatf("abort_r%0d", i), reg0, 16'h0000);
        end

        issue(1, 16'h0010, 16'h00FF, 4'd0, 16'h00FF, 1'b0, 1'b0, 1'b0, 2, 1'b0);
        issue(1, 16'h0014, 16'h0001, 4'd1, 16'h0001, 1'b0, 1'b0, 1'b0, 2, 1'b0);
        issue(1, 16'h0021, 16'h0000, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 4, 1'b0);
        issue(1, 16'h0089, 16'h0000, 4'd2, 16'h00FF, 1'b0, 1'b0, 1'b0, 3, 1'b0);
        issue(1, 16'h00AC, 16'h0000, 4'd3, 16'h0000, 1'b1, 1'b0, 1'b0, 3, 1'b0);

        repeat (2) @(negedge clk);
        chk("sb_drained", 16'(q.size()), 16'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/param_processor.md
Name: param_processor

Overview:
- Parametrised successor of the team's 8-register, 16-bit, switch-driven multi-cycle processor.
- Data width and register count are generic. Instructions start with a run/done/busy handshake instead of a free-running step counter.
- The datapath gains an immediate-load instruction, XOR, shift, Z/C flags, illegal-opcode detection and a read-only register view port for the display logic.
- Sits between the board's debounced clock/switch inputs and the seven-segment driver.

Parameters:
- DATA_W, 16, width of registers, bus and dataIn; must satisfy DATA_W >= 4 + 2*REG_IDX_W.
- NREGS, 8, number of general registers R0..R(NREGS-1); power of two, 2..16.
- REG_IDX_W (localparam), $clog2(NREGS), width of a register index field.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- run  in  1  start request; sampled only in IDLE.
- dataIn  in  DATA_W  instruction word in IDLE; immediate operand in T1 of MVI.
- done  out  1  high for exactly the final step cycle of an instruction, combinational from state.
- busy  out  1  high whenever state != IDLE.
- illegal  out  1  one-cycle pulse (T1) for an undefined opcode.
- bus  out  DATA_W  current internal bus value, combinational.
- regSel  in  REG_IDX_W  register selected for display.
- regOut  out  DATA_W  contents of R[regSel], combinational.
- flagZ  out  1  zero flag from the last ALU writeback.
- flagC  out  1  carry/borrow flag from the last ALU writeback.

Behaviour:
- Reset: clk and reset, synchronous and active-high. All R[i], A, G, IR, flagZ and flagC are cleared to 0 and the state goes to IDLE.
- Instruction format: opcode = dataIn[DATA_W-1:DATA_W-4]; X = [2*REG_IDX_W-1:REG_IDX_W]; Y = [REG_IDX_W-1:0]; all other bits are ignored.
- Opcodes: 0 MV Rx<=Ry; 1 MVI Rx<=imm; 2 ADD; 3 SUB Rx-Ry; 4 OR; 5 AND; 6 XOR; 7 NOT Rx<=~Ry; 8 NEG Rx<=-Ry; 9 SHL Rx<=Ry<<1; 10 SHR Rx<=Ry>>1 (logical). Opcodes 11-15 are illegal.
- States are IDLE, T1, T2, T3, encoded as 2 bits.
- IDLE:
  - bus = dataIn.
  - If run=1 at the edge: IR <= dataIn and the next state is T1. Otherwise stay in IDLE.
- T1:
  - MV: bus = R[Y]; R[X] <= bus; done=1; then IDLE.
  - MVI: bus = dataIn; R[X] <= bus; done=1; then IDLE.
  - Binary ops (2-6): bus = R[X]; A <= bus; then T2.
  - Unary ops (7-10): bus = R[Y]; A <= bus; then T2.
  - Illegal: illegal=1; done=1; no register or flag write; then IDLE.
- T2:
  - Binary ops: bus = R[Y]; G <= alu(A, bus); the computed Z/C are held in shadow bits; then T3.
  - Unary ops: bus = alu(A); R[X] <= bus; flags update; done=1; then IDLE.
- T3 (binary ops only): bus = G; R[X] <= G; flags take the shadow values; done=1; then IDLE.
- Latency, counted from the run-sampling edge:
  - MV, MVI, illegal: done in the next cycle (2 cycles total).
  - Unary ops: 3 cycles.
  - Binary ops: 4 cycles.
- Arithmetic is modulo 2^DATA_W with wrap-around.
- Carry flag:
  - ADD: C = carry-out.
  - SUB: C = 1 on borrow (A < operand, unsigned).
  - SHL: C = bit shifted out at the top (MSB).
  - SHR: C = bit shifted out at the bottom (bit 0).
  - OR, AND, XOR, NOT, NEG: C = 0.
- Zero flag: Z = (result == 0).
- MV and MVI do not change the flags.
- X == Y is legal. The source is read before the destination is written.
- run asserted while busy is ignored. Holding run high gives back-to-back instructions with exactly one IDLE cycle between them.
- Reset asserted mid-instruction aborts it: no writeback, done and busy are 0 in the following cycle, and all registers are 0.
- regOut is independent of the state machine. It shows the value after the write at the end of the writeback cycle.

Decomposition:
- Package param_processor_pkg holds:
  - opcode localparams OP_MV..OP_SHR;
  - the state encoding IDLE/T1/T2/T3;
  - the function is_binary(opcode).
- One combinational sub-module, param_processor_alu (parameter DATA_W):
  - inputs: op, a, b;
  - outputs: result, z, c.

Test Plan:
- DATA_W=16, NREGS=8; run=1 with dataIn=0x1000, then in T1 dataIn=0x0005 -> R0=0x0005, done in cycle 2, flags unchanged, regSel=0 gives regOut=0x0005.
- R0=0x0005, R1=0xFFFE; ADD R0,R1 (0x2001) -> busy for 4 cycles, done only in T3, R0=0x0003, C=1, Z=0.
- SUB R2,R2 with R2=0x1234 (0x3012) -> R2=0x0000, Z=1, C=0. Then SHR R3,R4 with R4=0x0001 -> R3=0, Z=1, C=1, done in cycle 3.
- dataIn=0xF000 with run=1 -> illegal and done both high in T1 only; no register or flag change; IDLE next cycle.
- reset=1 during T2 of ADD R0,R1 -> next cycle busy=0, done=0, all R=0, flags 0. run pulsed during T1/T2 of a normal ADD -> ignored, exactly one instruction executes.
- DATA_W=8, NREGS=4 build; R0=0xFF, R1=0x01, ADD R0,R1 (0x21) -> R0=0x00, Z=1, C=1. NEG R2,R1 -> R2=0xFF, C=0.
